// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR generator and its period monitor.
//   LFSR_WIDTH      : width of the LFSR state word
//   LFSR_MAX_PERIOD : default sample-count bound for the period monitor
//   lfsr_word_t     : one LFSR state word
//   pmon_state_t    : period monitor FSM states
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_WIDTH      = 16;
   localparam int LFSR_MAX_PERIOD = 2 ** LFSR_WIDTH;

   typedef logic [LFSR_WIDTH-1:0] lfsr_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } pmon_state_t;

endpackage : lfsr_pkg

// File: rtl/lfsr_period_mon_if.sv
// -----------------------------------------------------------------------------
// lfsr_period_mon_if
// Command/sample/result bundle of the LFSR period monitor.
//   start, valid_in, lfsr_in           : driven by the master (controller/LFSR)
//   busy, done, period, lockup, timeout : driven by the slave (monitor)
// -----------------------------------------------------------------------------
interface lfsr_period_mon_if
   import lfsr_pkg::*;
#(
   parameter int WIDTH = LFSR_WIDTH,
   parameter int CNT_W = $clog2(LFSR_MAX_PERIOD + 1)
);
   logic             start;
   logic             valid_in;
   logic [WIDTH-1:0] lfsr_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] period;
   logic             lockup;
   logic             timeout;

   modport master (
      output start, valid_in, lfsr_in,
      input  busy, done, period, lockup, timeout
   );

   modport slave (
      input  start, valid_in, lfsr_in,
      output busy, done, period, lockup, timeout
   );
endinterface : lfsr_period_mon_if

// File: rtl/flop.sv
// -----------------------------------------------------------------------------
// flop
// Plain WIDTH-bit register with synchronous active-high reset to zero.
//   clk   : clock
//   reset : synchronous reset, active high
//   d_i   : next value
//   q_o   : registered value
// -----------------------------------------------------------------------------
module flop #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_o <= {WIDTH{1'b0}};
      end else begin
         q_o <= d_i;
      end
   end

endmodule : flop

// File: rtl/lfsr_period_mon.sv
// -----------------------------------------------------------------------------
// lfsr_period_mon
// Measures the period of an LFSR sample stream. On start, the first valid
// sample becomes the reference; valid samples are then counted until the
// reference recurs. Also flags an all-zero (lockup) sample and a missing
// repeat within MAX_PERIOD samples (timeout).
//   clk   : clock, rising edge
//   reset : synchronous reset, active high
//   bus   : slave side of lfsr_period_mon_if
//           start/valid_in/lfsr_in in; busy/done/period/lockup/timeout out
// -----------------------------------------------------------------------------
module lfsr_period_mon
   import lfsr_pkg::*;
#(
   parameter int WIDTH      = LFSR_WIDTH,
   parameter int MAX_PERIOD = 2 ** WIDTH,
   parameter int CNT_W      = $clog2(MAX_PERIOD + 1)
) (
   input  logic               clk,
   input  logic               reset,
   lfsr_period_mon_if.slave   bus
);

   pmon_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_n_s;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             lockup_q, lockup_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             ref_load_s;
   logic             zero_s;
   logic             match_s;

   // Reference word register; holds its value unless the ARM state loads it.
   flop #(.WIDTH(WIDTH)) u_ref_flop (
      .clk   (clk),
      .reset (reset),
      .d_i   (ref_d),
      .q_o   (ref_q)
   );

   assign ref_d   = ref_load_s ? bus.lfsr_in : ref_q;
   assign cnt_n_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   assign zero_s  = (bus.lfsr_in == {WIDTH{1'b0}});
   assign match_s = (bus.lfsr_in == ref_q);

   // Next-state, counter and result logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      period_d   = period_q;
      lockup_d   = lockup_q;
      timeout_d  = timeout_q;
      ref_load_s = 1'b0;

      case (state_q)
         IDLE: begin
            done_d    = 1'b0;
            period_d  = {CNT_W{1'b0}};
            lockup_d  = 1'b0;
            timeout_d = 1'b0;
            if (bus.start) begin
               state_d = ARM;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         ARM: begin
            if (bus.valid_in) begin
               ref_load_s = 1'b1;
               cnt_d      = {CNT_W{1'b0}};
               if (zero_s) begin
                  // Reference itself is the lockup word: nothing to count.
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  lockup_d = 1'b1;
                  period_d = {CNT_W{1'b0}};
               end else begin
                  state_d = COUNT;
               end
            end else begin
               state_d = ARM;
            end
         end

         COUNT: begin
            if (bus.valid_in) begin
               // Priority: lockup, then match, then timeout.
               if (zero_s) begin
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  lockup_d = 1'b1;
                  period_d = {CNT_W{1'b0}};
               end else if (match_s) begin
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  period_d = cnt_n_s;
               end else if (cnt_n_s == CNT_W'(MAX_PERIOD)) begin
                  state_d   = DONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  period_d  = CNT_W'(MAX_PERIOD);
               end else begin
                  cnt_d = cnt_n_s;
               end
            end else begin
               state_d = COUNT;
            end
         end

         DONE: begin
            if (bus.start) begin
               // Restart clears the previous result on the same edge.
               state_d   = ARM;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               period_d  = {CNT_W{1'b0}};
               lockup_d  = 1'b0;
               timeout_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            period_d  = {CNT_W{1'b0}};
            lockup_d  = 1'b0;
            timeout_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         period_q  <= {CNT_W{1'b0}};
         lockup_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         period_q  <= period_d;
         lockup_q  <= lockup_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.period  = period_q;
   assign bus.lockup  = lockup_q;
   assign bus.timeout = timeout_q;

endmodule : lfsr_period_mon

// File: tb/tb_lfsr_period_mon.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_mon
// Two monitor instances: one with the default bound (2**16) and one with
// MAX_PERIOD=8. A driver issues measurements and pushes the expected result
// into a per-instance scoreboard; a monitor pops it on every rising done.
// -----------------------------------------------------------------------------
module tb_lfsr_period_mon;
   import lfsr_pkg::*;

   localparam int W    = 16;
   localparam int MAXA = 65536;
   localparam int CWA  = 17;
   localparam int MAXB = 8;
   localparam int CWB  = 4;

   typedef struct {
      int period;
      int lockup;
      int timeout;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   lfsr_period_mon_if #(.WIDTH(W), .CNT_W(CWA)) bus_a ();
   lfsr_period_mon_if #(.WIDTH(W), .CNT_W(CWB)) bus_b ();

   lfsr_period_mon #(.WIDTH(W), .MAX_PERIOD(MAXA), .CNT_W(CWA)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   lfsr_period_mon #(.WIDTH(W), .MAX_PERIOD(MAXB), .CNT_W(CWB)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit use8, input bit st, input bit v, input lfsr_word_t d);
      if (use8) begin
         bus_b.start = st; bus_b.valid_in = v; bus_b.lfsr_in = d;
      end else begin
         bus_a.start = st; bus_a.valid_in = v; bus_a.lfsr_in = d;
      end
   endtask

   function automatic int o_busy(input bit use8);
      return use8 ? int'(bus_b.busy) : int'(bus_a.busy);
   endfunction
   function automatic int o_done(input bit use8);
      return use8 ? int'(bus_b.done) : int'(bus_a.done);
   endfunction
   function automatic int o_period(input bit use8);
      return use8 ? int'(bus_b.period) : int'(bus_a.period);
   endfunction
   function automatic int o_lockup(input bit use8);
      return use8 ? int'(bus_b.lockup) : int'(bus_a.lockup);
   endfunction
   function automatic int o_timeout(input bit use8);
      return use8 ? int'(bus_b.timeout) : int'(bus_a.timeout);
   endfunction

   // Fibonacci LFSR, taps 16,14,13,11, shifting right.
   function automatic lfsr_word_t lfsr_step(input lfsr_word_t s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   // Reference model: scan the valid-sample list. Returns how many samples
   // are consumed up to the terminating one, or -1 if none terminates.
   function automatic int model(input lfsr_word_t s[$], input int maxp, output exp_t e);
      e.period = 0; e.lockup = 0; e.timeout = 0;
      if (s.size() == 0) return -1;
      if (s[0] == 16'h0000) begin
         e.lockup = 1;
         return 1;
      end
      for (int i = 1; i < s.size(); i++) begin
         if (s[i] == 16'h0000) begin
            e.lockup = 1;
            return i + 1;
         end
         if (s[i] == s[0]) begin
            e.period = i;
            return i + 1;
         end
         if (i == maxp) begin
            e.timeout = 1;
            e.period  = maxp;
            return i + 1;
         end
      end
      return -1;
   endfunction

   // One measurement: start, samples with bubbles, optional start pokes in COUNT.
   task automatic measure(input bit use8, input lfsr_word_t s[$], input int bmin,
                          input int bmax, input bit poke, input string tag);
      exp_t e;
      int   n;
      int   b;
      n = model(s, use8 ? MAXB : MAXA, e);
      if (n < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: stimulus has no terminating sample", tag);
         return;
      end
      if (use8) sb_b.push_back(e);
      else      sb_a.push_back(e);

      drive(use8, 1'b1, 1'b0, 16'h0000);
      step();
      drive(use8, 1'b0, 1'b0, 16'h0000);
      check({tag, " busy_rise"}, o_busy(use8), 1);

      for (int i = 0; i < n; i++) begin
         b = int'($urandom_range(bmax, bmin));
         for (int j = 0; j < b; j++) begin
            drive(use8, poke && (i > 0) && (j == 0), 1'b0, lfsr_word_t'($urandom));
            step();
            if (poke && (i > 0) && (j == 0)) begin
               check({tag, " busy_hold"}, o_busy(use8), 1);
               check({tag, " done_hold"}, o_done(use8), 0);
            end
         end
         drive(use8, 1'b0, 1'b1, s[i]);
         step();
      end
      check({tag, " done_lat"}, o_done(use8), 1);
      check({tag, " busy_fall"}, o_busy(use8), 0);
      drive(use8, 1'b0, 1'b0, 16'h0000);
      step();
      step();
   endtask

   exp_t ea;
   exp_t eb;
   logic done_a_prev = 1'b0;
   logic done_b_prev = 1'b0;

   // Scoreboard monitor for the default-bound instance.
   always @(negedge clk) begin
      if (bus_a.done && !done_a_prev) begin
         if (sb_a.size() == 0) begin
            check("a unexpected_done", 1, 0);
         end else begin
            ea = sb_a.pop_front();
            check("a period",  int'(bus_a.period),  ea.period);
            check("a lockup",  int'(bus_a.lockup),  ea.lockup);
            check("a timeout", int'(bus_a.timeout), ea.timeout);
         end
      end
      done_a_prev <= bus_a.done;
   end

   // Scoreboard monitor for the MAX_PERIOD=8 instance.
   always @(negedge clk) begin
      if (bus_b.done && !done_b_prev) begin
         if (sb_b.size() == 0) begin
            check("b unexpected_done", 1, 0);
         end else begin
            eb = sb_b.pop_front();
            check("b period",  int'(bus_b.period),  eb.period);
            check("b lockup",  int'(bus_b.lockup),  eb.lockup);
            check("b timeout", int'(bus_b.timeout), eb.timeout);
         end
      end
      done_b_prev <= bus_b.done;
   end

   // Global time bound.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      lfsr_word_t q[$];
      lfsr_word_t x;
      int         len;

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      step();
      step();
      for (int u = 0; u < 2; u++) begin
         check("rst busy",    o_busy(u[0]),    0);
         check("rst done",    o_done(u[0]),    0);
         check("rst period",  o_period(u[0]),  0);
         check("rst lockup",  o_lockup(u[0]),  0);
         check("rst timeout", o_timeout(u[0]), 0);
      end
      reset = 1'b0;
      step();

      // Directed period A,B,C,A.
      q = {16'h0001, 16'h0002, 16'h0003, 16'h0001};
      measure(1'b0, q, 0, 0, 1'b0, "dir");
      check("dir period_direct", o_period(1'b0), 3);

      // Lockup after one sample, and lockup on the reference itself.
      q = {16'h1234, 16'h0000};
      measure(1'b0, q, 0, 0, 1'b0, "lock1");
      check("lock1 lockup_direct", o_lockup(1'b0), 1);
      q = {16'h0000};
      measure(1'b0, q, 0, 0, 1'b0, "lock0");
      check("lock0 lockup_direct", o_lockup(1'b0), 1);
      check("lock0 period_direct", o_period(1'b0), 0);

      // Timeout on the 8-bound instance: 0x10..0x18.
      q.delete();
      for (int i = 0; i < 9; i++) q.push_back(lfsr_word_t'(16 + i));
      measure(1'b1, q, 0, 0, 1'b0, "tmo");
      check("tmo timeout_direct", o_timeout(1'b1), 1);
      check("tmo period_direct",  o_period(1'b1),  8);

      // Match exactly on the 8th sample beats timeout.
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(lfsr_word_t'(16 + i));
      q.push_back(16'h0010);
      measure(1'b1, q, 0, 0, 1'b0, "m8");
      check("m8 timeout_direct", o_timeout(1'b1), 0);
      check("m8 period_direct",  o_period(1'b1),  8);

      // Bubbles of 2 cycles and start pokes during COUNT.
      q = {16'h0001, 16'h0002, 16'h0003, 16'h0001};
      measure(1'b0, q, 2, 2, 1'b1, "bub");
      check("bub period_direct", o_period(1'b0), 3);

      // Reset in the middle of COUNT after two samples.
      drive(1'b0, 1'b1, 1'b0, 16'h0000); step();
      drive(1'b0, 1'b0, 1'b1, 16'h0001); step();
      drive(1'b0, 1'b0, 1'b1, 16'h0002); step();
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmid busy",    o_busy(1'b0),    0);
      check("rstmid done",    o_done(1'b0),    0);
      check("rstmid period",  o_period(1'b0),  0);
      check("rstmid lockup",  o_lockup(1'b0),  0);
      check("rstmid timeout", o_timeout(1'b0), 0);
      drive(1'b0, 1'b0, 1'b1, 16'h0001);
      step();
      check("rstmid idle_ignores_valid", o_busy(1'b0) + o_done(1'b0), 0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      q = {16'h0001, 16'h0002, 16'h0003, 16'h0001};
      measure(1'b0, q, 0, 0, 1'b0, "postrst");
      check("postrst period_direct", o_period(1'b0), 3);

      // Randomized streams on both instances.
      for (int k = 0; k < 30; k++) begin
         q.delete();
         len = int'($urandom_range(12, 2));
         for (int i = 0; i < len; i++) q.push_back(lfsr_word_t'($urandom_range(15, 0)));
         q[len-1] = q[0];
         measure(k[0], q, 0, 2, 1'(k % 3 == 0), k[0] ? "rnd_b" : "rnd_a");
      end

      // Full-length maximal LFSR from seed 0xACE1.
      q.delete();
      x = 16'hACE1;
      q.push_back(x);
      for (int i = 0; i < 65535; i++) begin
         x = lfsr_step(x);
         q.push_back(x);
      end
      measure(1'b0, q, 0, 0, 1'b0, "full");
      check("full period_direct",  o_period(1'b0),  65535);
      check("full timeout_direct", o_timeout(1'b0), 0);
      check("full lockup_direct",  o_lockup(1'b0),  0);

      step();
      step();
      check("sb_a drained", sb_a.size(), 0);
      check("sb_b drained", sb_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_lfsr_period_mon

// File: doc/lfsr_period_mon.md
# lfsr_period_mon

Streaming checker that sits directly downstream of the `lfsr` stage and consumes its 16-bit state output. On command it latches the first valid sample as a reference, then counts valid samples until that value recurs, and reports the sequence period. It also flags all-zero lockup and a missing repeat within a bound. It replaces software repeat detection with a synthesizable self-test that the `lfsr`/`flop` loop can drive in-system.

## Interface
Parameters:
- `WIDTH`, 16, width of the LFSR word.
- `MAX_PERIOD`, 2**WIDTH, sample-count bound before timeout.
- `CNT_W`, $clog2(MAX_PERIOD+1), width of the period counter and output.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; applies on the `clk` rising edge.
- `start`  in  1  begin a measurement; sampled in IDLE or DONE only.
- `valid_in`  in  1  `lfsr_in` carries a new sample this cycle.
- `lfsr_in`  in  WIDTH  LFSR state word from the upstream stage.
- `busy`  out  1  high in ARM and COUNT.
- `done`  out  1  level, high in DONE until the next accepted `start` or `reset`.
- `period`  out  CNT_W  measured period; valid while `done`=1.
- `lockup`  out  1  an all-zero sample was seen; valid while `done`=1.
- `timeout`  out  1  no repeat within MAX_PERIOD samples; valid while `done`=1.

## Operation
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - `start`=1 -> ARM.
  - Clears `done`, `period`, `lockup` and `timeout`.
- ARM:
  - Waits for `valid_in`.
  - Latches `ref <= lfsr_in` and `cnt <= 0` -> COUNT.
  - If that sample is 0 -> DONE with `lockup`=1, `period`=0.
- COUNT, on each `valid_in`, with `cnt_n = cnt+1`:
  - `lfsr_in == 0` -> DONE, `lockup`=1, `period`=0.
  - Else `lfsr_in == ref` -> DONE, `period`=`cnt_n`.
  - Else `cnt_n == MAX_PERIOD` -> DONE, `timeout`=1, `period`=MAX_PERIOD.
  - Else `cnt <= cnt_n`.
- Priority in COUNT: lockup > match > timeout. A match on the MAX_PERIOD-th sample reports a match, not a timeout.
- DONE:
  - Holds all outputs.
  - `start`=1 -> ARM and clears the result outputs on the same edge.
- `valid_in`=0 in any state: no counting, no state change; bubbles do not affect `period`.
- `start` in ARM or COUNT: ignored.
- Period definition: samples after the reference, up to and including the first repeat. Stream A,B,C,A gives 3.
- Counter arithmetic is unsigned, CNT_W bits. No wrap is possible because `cnt` never exceeds MAX_PERIOD.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `period`=0, `lockup`=0, `timeout`=0; `ref` and `cnt` = 0.
- Reset mid-measurement aborts in one cycle and returns to these values. No partial result is retained.
- All outputs are registered; there is no combinational path from input to output.
- `busy` rises the cycle after `start` is accepted.
- `done` and the result rise the cycle after the terminating sample. `busy` falls on the same edge.
- Throughput: one sample per clock; `valid_in` may stay high continuously.
- `start` and a terminating sample cannot coincide, because `start` is ignored in COUNT.

## Structure
- Shared package `lfsr_pkg`:
  - `LFSR_WIDTH`=16.
  - `LFSR_MAX_PERIOD`.
  - Typedef `lfsr_word_t` (logic [LFSR_WIDTH-1:0]).
  - Enum `pmon_state_t` {IDLE, ARM, COUNT, DONE}.
- One sub-module: the existing `flop #(WIDTH)` holds `ref`, with an enable mux in front.
- FSM, counter, comparators and result registers stay in `lfsr_period_mon`.

## Test plan
- Directed period: `start`, then `lfsr_in` 0x0001, 0x0002, 0x0003, 0x0001 with `valid_in`=1.
  - Required: `done`=1 and `period`=3 one cycle after the 4th sample; `lockup`=0, `timeout`=0.
- Full-length LFSR: drive from `lfsr` (seed 0xACE1, taps 16,14,13,11).
  - Required: `period`=65535, `timeout`=0, `lockup`=0.
- Lockup: `start`, then samples 0x1234, 0x0000.
  - Required: `done`=1, `lockup`=1, `period`=0.
  - Repeat the run with the first sample 0x0000; the same result is required.
- Timeout: with MAX_PERIOD=8, feed an incrementing stream from 0x0010.
  - Required: `timeout`=1 and `period`=8 after the 9th sample.
  - A variant where the ref repeats exactly at sample 8 is required to report a match with `period`=8 and `timeout`=0.
- Bubbles and ignored start: repeat the directed-period scenario with `valid_in` low for 2 cycles between samples, and pulse `start` during COUNT.
  - Required: `period`=3 and an unchanged FSM.
- Reset mid-COUNT: assert `reset` for 1 cycle after 2 samples.
  - Required: all outputs 0 and IDLE on the next cycle.
  - A subsequent `start` plus the directed-period stream is required to give `period`=3.
